// File: rtl/phase_timer.sv
// Phase duration timer for the wash-cycle controller: times fill/wash/rinse/spin
// in minutes built from a clk prescaler and reports completion back to the FSM.
module phase_timer #(
  parameter int unsigned TICKS_PER_MIN = 4,
  parameter int unsigned FILL_MIN      = 2,
  parameter int unsigned WASH_MIN      = 5,
  parameter int unsigned RINSE_MIN     = 2,
  parameter int unsigned WASH2_MIN     = 3,
  parameter int unsigned RINSE2_MIN    = 2,
  parameter int unsigned SPIN_MIN      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_rst1,
  input  logic       soft_rst2,
  input  logic       start_Filling,
  input  logic       start_washing,
  input  logic       start_Rinsing,
  input  logic       start_spining,
  input  logic       round2_washing,
  input  logic       round2_Rinsing,
  input  logic       spining_counter_stop,
  output logic       Filling_water_done,
  output logic       Washing_done,
  output logic       Rinsing_done,
  output logic       spining_done,
  output logic [2:0] phase_o,
  output logic [7:0] minutes_left,
  output logic       second_round
);

  localparam int unsigned TW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MIN - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  typedef enum logic [2:0] {
    PH_NONE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4
  } phase_t;

  phase_t          phase_r, phase_nxt_s, req_s;
  logic [TW-1:0]   tick_r, tick_nxt_s;
  logic [7:0]      min_r, min_nxt_s;
  logic            second_r, second_nxt_s;
  logic [7:0]      dur_s;
  logic            soft_clr_s;
  logic            frozen_s;
  logic            sat_s;

  assign soft_clr_s = ~soft_rst1 | ~soft_rst2;
  assign frozen_s   = spining_counter_stop && (phase_r == PH_SPIN);
  assign sat_s      = (min_r == dur_s);

  // Requested phase: the later phase wins while the FSM overlaps two starts.
  always_comb begin
    req_s = PH_NONE;
    if (start_spining) begin
      req_s = PH_SPIN;
    end else if (start_Rinsing) begin
      req_s = PH_RINSE;
    end else if (start_washing) begin
      req_s = PH_WASH;
    end else if (start_Filling) begin
      req_s = PH_FILL;
    end else begin
      req_s = PH_NONE;
    end
  end

  // Duration of the registered phase, round-2 aware.
  always_comb begin
    dur_s = 8'd0;
    case (phase_r)
      PH_FILL:  dur_s = 8'(FILL_MIN);
      PH_WASH:  dur_s = second_r ? 8'(WASH2_MIN) : 8'(WASH_MIN);
      PH_RINSE: dur_s = second_r ? 8'(RINSE2_MIN) : 8'(RINSE_MIN);
      PH_SPIN:  dur_s = 8'(SPIN_MIN);
      default:  dur_s = 8'd0;
    endcase
  end

  // Next-state: soft clear, phase change restart, then saturating prescaled count.
  always_comb begin
    phase_nxt_s  = phase_r;
    tick_nxt_s   = tick_r;
    min_nxt_s    = min_r;
    second_nxt_s = second_r;
    if (soft_clr_s) begin
      phase_nxt_s  = PH_NONE;
      tick_nxt_s   = '0;
      min_nxt_s    = 8'd0;
      second_nxt_s = 1'b0;
    end else begin
      if (round2_washing || round2_Rinsing) begin
        second_nxt_s = 1'b1;
      end else begin
        second_nxt_s = second_r;
      end
      if (req_s != phase_r) begin
        phase_nxt_s = req_s;
        tick_nxt_s  = '0;
        min_nxt_s   = 8'd0;
      end else if ((phase_r != PH_NONE) && !frozen_s && !sat_s) begin
        if (tick_r == TICK_LAST) begin
          tick_nxt_s = '0;
          min_nxt_s  = min_r + 8'd1;
        end else begin
          tick_nxt_s = tick_r + TICK_ONE;
          min_nxt_s  = min_r;
        end
      end else begin
        tick_nxt_s = tick_r;
        min_nxt_s  = min_r;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r  <= PH_NONE;
      tick_r   <= '0;
      min_r    <= 8'd0;
      second_r <= 1'b0;
    end else begin
      phase_r  <= phase_nxt_s;
      tick_r   <= tick_nxt_s;
      min_r    <= min_nxt_s;
      second_r <= second_nxt_s;
    end
  end

  // Done is qualified by the live start so it drops as soon as the FSM moves on.
  assign Filling_water_done = (phase_r == PH_FILL)  && sat_s && start_Filling;
  assign Washing_done       = (phase_r == PH_WASH)  && sat_s && start_washing;
  assign Rinsing_done       = (phase_r == PH_RINSE) && sat_s && start_Rinsing;
  assign spining_done       = (phase_r == PH_SPIN)  && sat_s && start_spining;

  assign phase_o      = phase_r;
  assign minutes_left = (phase_r != PH_NONE) ? (dur_s - min_r) : 8'd0;
  assign second_round = second_r;

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer: table-driven fill/wash run plus
// hand-built sequences for round 2, spin freeze, clears and abort/restart.
module tb_phase_timer;
  logic       clk = 1'b0;
  logic       rst_n, soft_rst1, soft_rst2;
  logic       start_Filling, start_washing, start_Rinsing, start_spining;
  logic       round2_washing, round2_Rinsing, spining_counter_stop;
  logic       Filling_water_done, Washing_done, Rinsing_done, spining_done;
  logic [2:0] phase_o;
  logic [7:0] minutes_left;
  logic       second_round;

  int checks = 0;
  int errors = 0;

  // start/done nibbles are {spin, rinse, wash, fill}
  typedef struct {
    logic [3:0] start;
    logic       r2w;
    logic       r2r;
    logic       stop;
    logic       s1;
    logic       s2;
    logic [3:0] done;
    logic [2:0] ph;
    logic [7:0] ml;
    logic       ml_chk;
    logic       sr;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[32];

  phase_timer #(
    .TICKS_PER_MIN(4), .FILL_MIN(2), .WASH_MIN(5), .RINSE_MIN(2),
    .WASH2_MIN(3), .RINSE2_MIN(2), .SPIN_MIN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst1(soft_rst1), .soft_rst2(soft_rst2),
    .start_Filling(start_Filling), .start_washing(start_washing),
    .start_Rinsing(start_Rinsing), .start_spining(start_spining),
    .round2_washing(round2_washing), .round2_Rinsing(round2_Rinsing),
    .spining_counter_stop(spining_counter_stop),
    .Filling_water_done(Filling_water_done), .Washing_done(Washing_done),
    .Rinsing_done(Rinsing_done), .spining_done(spining_done),
    .phase_o(phase_o), .minutes_left(minutes_left), .second_round(second_round)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [3:0] start, logic [3:0] done, logic [2:0] ph,
                              logic [7:0] ml, logic sr);
    vec_t v;
    v.start = start; v.r2w = 1'b0; v.r2r = 1'b0; v.stop = 1'b0;
    v.s1 = 1'b1; v.s2 = 1'b1;
    v.done = done; v.ph = ph; v.ml = ml; v.ml_chk = 1'b1; v.sr = sr;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    start_Filling        = v.start[0];
    start_washing        = v.start[1];
    start_Rinsing        = v.start[2];
    start_spining        = v.start[3];
    round2_washing       = v.r2w;
    round2_Rinsing       = v.r2r;
    spining_counter_stop = v.stop;
    soft_rst1            = v.s1;
    soft_rst2            = v.s2;
  endtask

  task automatic check_now(input string name);
    vec_t e;
    logic [3:0] got_done;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      got_done = {spining_done, Rinsing_done, Washing_done, Filling_water_done};
      if (got_done !== e.done || phase_o !== e.ph || second_round !== e.sr ||
          (e.ml_chk && minutes_left !== e.ml)) begin
        errors++;
        $display("FAIL %s: got done=%b phase=%0d min_left=%0d r2=%b, expected done=%b phase=%0d min_left=%0d r2=%b",
                 name, got_done, phase_o, minutes_left, second_round,
                 e.done, e.ph, e.ml, e.sr);
      end
    end
  endtask

  task automatic step(input vec_t v, input string name);
    @(posedge clk);
    #1;
    apply(v);
    exp_q.push_back(v);
    @(negedge clk);
    check_now(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int m;

    // Fill (FILL=2) then handover to wash (WASH=5); wash c0 is the overlap cycle 9.
    for (int k = 0; k < 32; k++) begin
      if (k == 0) begin
        v = mk(4'b0001, 4'b0000, 3'd0, 8'd0, 1'b0);
        v.ml_chk = 1'b0;
      end else if (k <= 9) begin
        m = (k - 1) / 4; if (m > 2) m = 2;
        v = mk((k == 9) ? 4'b0011 : 4'b0001, (k >= 9) ? 4'b0001 : 4'b0000,
               3'd1, 8'(2 - m), 1'b0);
      end else begin
        m = (k - 10) / 4; if (m > 5) m = 5;
        v = mk(4'b0010, (k >= 30) ? 4'b0010 : 4'b0000, 3'd2, 8'(5 - m), 1'b0);
      end
      tbl[k] = v;
    end

    v = mk(4'b0000, 4'b0000, 3'd0, 8'd0, 1'b0);
    apply(v);
    rst_n = 1'b0;
    #12;
    exp_q.push_back(v);
    check_now("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 32; k++) step(tbl[k], $sformatf("fill_wash[%0d]", k));
    step(mk(4'b0000, 4'b0000, 3'd2, 8'd0, 1'b0), "wash_drop");
    step(mk(4'b0000, 4'b0000, 3'd0, 8'd0, 1'b0), "wash_idle");

    // Double wash / rinse with round-2 durations, then soft_rst1 clear.
    v = mk(4'b0010, 4'b0000, 3'd0, 8'd0, 1'b0); v.r2w = 1'b1;
    step(v, "dw_c0");
    for (int k = 1; k <= 13; k++) begin
      m = (k - 1) / 4; if (m > 3) m = 3;
      step(mk(4'b0010, (k >= 13) ? 4'b0010 : 4'b0000, 3'd2, 8'(3 - m), 1'b1),
           $sformatf("dw[%0d]", k));
    end
    v = mk(4'b0110, 4'b0010, 3'd2, 8'd0, 1'b1); v.r2r = 1'b1;
    step(v, "dr_c0");
    for (int k = 15; k <= 23; k++) begin
      m = (k - 15) / 4; if (m > 2) m = 2;
      step(mk(4'b0100, (k >= 23) ? 4'b0100 : 4'b0000, 3'd3, 8'(2 - m), 1'b1),
           $sformatf("dr[%0d]", k));
    end
    v = mk(4'b0100, 4'b0100, 3'd3, 8'd0, 1'b1); v.s1 = 1'b0;
    step(v, "srst1_assert");
    step(mk(4'b0100, 4'b0000, 3'd0, 8'd0, 1'b0), "srst1_cleared");
    step(mk(4'b0100, 4'b0000, 3'd3, 8'd2, 1'b0), "rinse1_dur");
    step(mk(4'b0000, 4'b0000, 3'd3, 8'd2, 1'b0), "rinse1_drop");
    step(mk(4'b0000, 4'b0000, 3'd0, 8'd0, 1'b0), "rinse1_idle");

    // Spin with a 7-cycle freeze, freeze during done, then soft_rst2 clear.
    step(mk(4'b1000, 4'b0000, 3'd0, 8'd0, 1'b0), "spin_c0");
    for (int k = 1; k <= 16; k++) begin
      v = mk(4'b1000, (k >= 12) ? 4'b1000 : 4'b0000, 3'd4,
             (k >= 12) ? 8'd0 : 8'd1, 1'b0);
      v.stop = ((k >= 2 && k <= 8) || (k >= 13 && k <= 15)) ? 1'b1 : 1'b0;
      step(v, $sformatf("spin[%0d]", k));
    end
    v = mk(4'b1000, 4'b1000, 3'd4, 8'd0, 1'b0); v.s2 = 1'b0;
    step(v, "srst2_assert");
    step(mk(4'b0000, 4'b0000, 3'd0, 8'd0, 1'b0), "srst2_cleared");

    // Rinse abort for one cycle, then full restart.
    step(mk(4'b0100, 4'b0000, 3'd0, 8'd0, 1'b0), "ab_c0");
    for (int k = 1; k <= 3; k++)
      step(mk(4'b0100, 4'b0000, 3'd3, 8'd2, 1'b0), $sformatf("ab[%0d]", k));
    step(mk(4'b0000, 4'b0000, 3'd3, 8'd2, 1'b0), "ab_drop");
    step(mk(4'b0100, 4'b0000, 3'd0, 8'd0, 1'b0), "ab_reenter");
    for (int k = 6; k <= 14; k++) begin
      m = (k - 6) / 4; if (m > 2) m = 2;
      step(mk(4'b0100, (k >= 14) ? 4'b0100 : 4'b0000, 3'd3, 8'(2 - m), 1'b0),
           $sformatf("ab[%0d]", k));
    end
    step(mk(4'b0000, 4'b0000, 3'd3, 8'd0, 1'b0), "ab_drop2");
    step(mk(4'b0000, 4'b0000, 3'd0, 8'd0, 1'b0), "ab_idle");

    // Asynchronous reset mid-wash (round 2 active), no clock edge needed.
    v = mk(4'b0010, 4'b0000, 3'd0, 8'd0, 1'b0); v.r2w = 1'b1;
    step(v, "ar_c0");
    for (int k = 1; k <= 3; k++)
      step(mk(4'b0010, 4'b0000, 3'd2, 8'd3, 1'b1), $sformatf("ar[%0d]", k));
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(4'b0010, 4'b0000, 3'd0, 8'd0, 1'b0));
    check_now("async_rst");
    @(negedge clk);
    exp_q.push_back(mk(4'b0010, 4'b0000, 3'd0, 8'd0, 1'b0));
    check_now("async_rst_hold");
    apply(mk(4'b0000, 4'b0000, 3'd0, 8'd0, 1'b0));
    rst_n = 1'b1;
    step(mk(4'b0000, 4'b0000, 3'd0, 8'd0, 1'b0), "post_rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
